load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store engine over a word-addressed data memory.
// Define LSU_MISALIGN_SPLIT_EN to run word-spanning accesses as two memory cycles instead of erroring.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_we,
  input  logic [2:0]            lsu_req_funct3,
  input  logic [31:0]           lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  lsu_resp_error,
  output logic [ADDR_WIDTH-1:0] dataMem_addr,
  output logic [DATA_WIDTH-1:0] dataMem_in,
  output logic [3:0]            dataMem_WE_L,
  input  logic [DATA_WIDTH-1:0] dataMem_out
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t                  state_q, state_d;
  logic                    we_q, we_d, err_q, err_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, word0_q, word0_d, rdata_q, rdata_d;
  logic [1:0]              o_q;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic                    req_bad, st_act, st_hi, unused_addr_hi;
  logic [2*DATA_WIDTH-1:0] wd_sh, ld_cat;
  logic [7:0]              mask8;
  logic [DATA_WIDTH-1:0]   ld_word, ld_res;
  function automatic logic [3:0] size_of(input logic [1:0] f);
    return f == 2'b00 ? 4'd1 : f == 2'b01 ? 4'd2 : 4'd4;
  endfunction
  function automatic logic spans(input logic [1:0] o, input logic [1:0] f);
    return ({2'b00, o} + size_of(f)) > 4'd4;
  endfunction
  function automatic logic legal(input logic we, input logic [2:0] f);
    return we ? (f <= 3'd2) : (f[1:0] != 2'b11 && !(f[2] && f[1]));
  endfunction
  assign unused_addr_hi = ^lsu_req_addr[31:ADDR_WIDTH+2];
  assign o_q    = addr_q[1:0];
  assign word_q = addr_q[ADDR_WIDTH+1:2];
  assign req_bad = !legal(lsu_req_we, lsu_req_funct3) ||
                   (!SPLIT_EN && spans(lsu_req_addr[1:0], lsu_req_funct3[1:0]));
  // Loads see {word1, word0} in ACC1; in ACC0 only the current word matters.
  assign ld_cat  = state_q == ACC1 ? {dataMem_out, word0_q} : {{DATA_WIDTH{1'b0}}, dataMem_out};
  assign ld_word = ld_cat[{3'b000, o_q, 3'b000} +: DATA_WIDTH];
  assign ld_res  = we_q ? '0 :
                   funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & ld_word[7]}}, ld_word[7:0]} :
                   funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & ld_word[15]}}, ld_word[15:0]} :
                   ld_word;
  assign wd_sh  = {{DATA_WIDTH{1'b0}}, wdata_q} << {o_q, 3'b000};
  assign mask8  = {4'b0000, funct3_q[1:0] == 2'b00 ? 4'b0001 :
                            funct3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111} << o_q;
  assign st_hi  = state_q == ACC1;
  assign st_act = we_q && (state_q == ACC0 || st_hi);
  assign lsu_req_ready  = state_q == IDLE;
  assign lsu_resp_valid = state_q == RESP;
  assign lsu_resp_rdata = lsu_resp_valid ? rdata_q : '0;
  assign lsu_resp_error = lsu_resp_valid & err_q;
  assign dataMem_addr   = st_hi ? word_q + 1'b1 : state_q == ACC0 ? word_q : '0;
  assign dataMem_in     = st_act ? (st_hi ? wd_sh[2*DATA_WIDTH-1:DATA_WIDTH] : wd_sh[DATA_WIDTH-1:0]) : '0;
  assign dataMem_WE_L   = st_act ? ~(st_hi ? mask8[7:4] : mask8[3:0]) : 4'b1111;
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word0_d  = word0_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (lsu_req_valid) begin
        we_d     = lsu_req_we;
        funct3_d = lsu_req_funct3;
        addr_d   = lsu_req_addr[ADDR_WIDTH+1:0];
        wdata_d  = lsu_req_wdata;
        rdata_d  = '0;
        err_d    = req_bad;
        state_d  = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        word0_d = dataMem_out;
        rdata_d = ld_res;
        state_d = SPLIT_EN && spans(o_q, funct3_q[1:0]) ? ACC1 : RESP;
      end
      ACC1: begin
        rdata_d = ld_res;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word0_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word0_q  <= word0_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table of loads/stores against a byte-lane memory model, plus reset and split corners.
module tb_load_store_unit;
  logic        clock = 1'b0, reset_L = 1'b0;
  logic        lsu_req_valid = 1'b0, lsu_req_we = 1'b0;
  logic [2:0]  lsu_req_funct3 = '0;
  logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0;
  logic        lsu_req_ready, lsu_resp_valid, lsu_resp_error;
  logic [31:0] lsu_resp_rdata, dataMem_in, dataMem_out;
  logic [11:0] dataMem_addr;
  logic [3:0]  dataMem_WE_L;
  logic [31:0] mem [0:4095];
  int checks = 0, failures = 0;

  load_store_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset_L(reset_L),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_we(lsu_req_we), .lsu_req_funct3(lsu_req_funct3),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_error(lsu_resp_error),
    .dataMem_addr(dataMem_addr), .dataMem_in(dataMem_in),
    .dataMem_WE_L(dataMem_WE_L), .dataMem_out(dataMem_out)
  );

  always #5 clock = ~clock;
  assign dataMem_out = mem[dataMem_addr];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    forever begin
      @(posedge clock);
      for (int l = 0; l < 4; l++)
        if (!dataMem_WE_L[l]) mem[dataMem_addr][8*l +: 8] <= dataMem_in[8*l +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          lat;
    logic [11:0] a0;
    logic [3:0]  we0;
    logic [31:0] in0;
  } vec_t;

  logic [31:0] rd, i0, i1;
  logic        er;
  int          lat;
  logic [11:0] a0, a1;
  logic [3:0]  w0, w1;

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic got;
    @(negedge clock);
    n = 0;
    while (!lsu_req_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    lsu_req_valid = 1'b1; lsu_req_we = we; lsu_req_funct3 = f3;
    lsu_req_addr = addr; lsu_req_wdata = wdata;
    @(posedge clock);
    #1 lsu_req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0; got = 1'b0;
    a0 = '0; a1 = '0; w0 = 4'hF; w1 = 4'hF; i0 = '0; i1 = '0;
    while (lat < 8 && !got) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin a0 = dataMem_addr; w0 = dataMem_WE_L; i0 = dataMem_in; end
      if (lat == 2) begin a1 = dataMem_addr; w1 = dataMem_WE_L; i1 = dataMem_in; end
      if (lsu_resp_valid) begin rd = lsu_resp_rdata; er = lsu_resp_error; got = 1'b1; end
    end
    if (!got) lat = 99;
  endtask

  vec_t tab [23];

  initial begin
    logic saw_resp;
    tab[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 12'h004, 4'h0, 32'hDEADBEEF};
    tab[1]  = '{1'b1, 3'd2, 32'h14,   32'h80FF7F01, 32'h0,        1'b0, 2, 12'h005, 4'h0, 32'h80FF7F01};
    tab[2]  = '{1'b1, 3'd2, 32'h3FFC, 32'hAABBCCDD, 32'h0,        1'b0, 2, 12'hFFF, 4'h0, 32'hAABBCCDD};
    tab[3]  = '{1'b0, 3'd2, 32'h10,   32'h5A5A5A5A, 32'hDEADBEEF, 1'b0, 2, 12'h004, 4'hF, 32'h0};
    tab[4]  = '{1'b0, 3'd0, 32'h17,   32'h5A5A5A5A, 32'hFFFFFF80, 1'b0, 2, 12'h005, 4'hF, 32'h0};
    tab[5]  = '{1'b0, 3'd4, 32'h17,   32'h5A5A5A5A, 32'h00000080, 1'b0, 2, 12'h005, 4'hF, 32'h0};
    tab[6]  = '{1'b0, 3'd1, 32'h15,   32'h5A5A5A5A, 32'hFFFFFF7F, 1'b0, 2, 12'h005, 4'hF, 32'h0};
    tab[7]  = '{1'b0, 3'd5, 32'h15,   32'h5A5A5A5A, 32'h0000FF7F, 1'b0, 2, 12'h005, 4'hF, 32'h0};
    tab[8]  = '{1'b1, 3'd0, 32'h22,   32'h000000AB, 32'h0,        1'b0, 2, 12'h008, 4'hB, 32'h00AB0000};
    tab[9]  = '{1'b0, 3'd2, 32'h20,   32'h5A5A5A5A, 32'h00AB0000, 1'b0, 2, 12'h008, 4'hF, 32'h0};
    tab[10] = '{1'b1, 3'd1, 32'h2A,   32'hFFFF1234, 32'h0,        1'b0, 2, 12'h00A, 4'h3, 32'h12340000};
    tab[11] = '{1'b0, 3'd2, 32'h28,   32'h5A5A5A5A, 32'h12340000, 1'b0, 2, 12'h00A, 4'hF, 32'h0};
    tab[12] = '{1'b0, 3'd0, 32'h13,   32'h5A5A5A5A, 32'hFFFFFFDE, 1'b0, 2, 12'h004, 4'hF, 32'h0};
    tab[13] = '{1'b0, 3'd1, 32'h11,   32'h5A5A5A5A, 32'hFFFFADBE, 1'b0, 2, 12'h004, 4'hF, 32'h0};
    tab[14] = '{1'b0, 3'd5, 32'h11,   32'h5A5A5A5A, 32'h0000ADBE, 1'b0, 2, 12'h004, 4'hF, 32'h0};
    tab[15] = '{1'b1, 3'd0, 32'h03,   32'h00000055, 32'h0,        1'b0, 2, 12'h000, 4'h7, 32'h55000000};
    tab[16] = '{1'b0, 3'd2, 32'h00,   32'h5A5A5A5A, 32'h55000000, 1'b0, 2, 12'h000, 4'hF, 32'h0};
    tab[17] = '{1'b0, 3'd3, 32'h10,   32'h5A5A5A5A, 32'h0,        1'b1, 1, 12'h000, 4'hF, 32'h0};
    tab[18] = '{1'b0, 3'd6, 32'h10,   32'h5A5A5A5A, 32'h0,        1'b1, 1, 12'h000, 4'hF, 32'h0};
    tab[19] = '{1'b1, 3'd4, 32'h40,   32'h00000077, 32'h0,        1'b1, 1, 12'h000, 4'hF, 32'h0};
    tab[20] = '{1'b1, 3'd3, 32'h40,   32'h00000077, 32'h0,        1'b1, 1, 12'h000, 4'hF, 32'h0};
    tab[21] = '{1'b0, 3'd2, 32'h40,   32'h5A5A5A5A, 32'h0,        1'b0, 2, 12'h010, 4'hF, 32'h0};
    tab[22] = '{1'b0, 3'd2, 32'h3FFC, 32'h5A5A5A5A, 32'hAABBCCDD, 1'b0, 2, 12'hFFF, 4'hF, 32'h0};

    #3;
    chk("rst_ready", {31'b0, lsu_req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, lsu_resp_valid}, 32'h0);
    chk("rst_rdata", lsu_resp_rdata, 32'h0);
    chk("rst_error", {31'b0, lsu_resp_error}, 32'h0);
    chk("rst_we_l", {28'b0, dataMem_WE_L}, 32'hF);
    chk("rst_mem_in", dataMem_in, 32'h0);
    chk("rst_mem_addr", {20'b0, dataMem_addr}, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;

    for (int i = 0; i < 23; i++) begin
      xact(tab[i].we, tab[i].f3, tab[i].addr, tab[i].wdata);
      chk($sformatf("v%0d_rdata", i), rd, tab[i].rdata);
      chk($sformatf("v%0d_error", i), {31'b0, er}, {31'b0, tab[i].err});
      chk($sformatf("v%0d_latency", i), lat, tab[i].lat);
      chk($sformatf("v%0d_acc0_addr", i), {20'b0, a0}, {20'b0, tab[i].a0});
      chk($sformatf("v%0d_acc0_we_l", i), {28'b0, w0}, {28'b0, tab[i].we0});
      chk($sformatf("v%0d_acc0_in", i), i0, tab[i].in0);
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    xact(1'b1, 3'd2, 32'h13, 32'h11223344);
    chk("split_sw_lat", lat, 3);
    chk("split_sw_err", {31'b0, er}, 32'h0);
    chk("split_sw_a0", {20'b0, a0}, 32'h4);
    chk("split_sw_w0", {28'b0, w0}, 32'h7);
    chk("split_sw_i0", i0, 32'h44000000);
    chk("split_sw_a1", {20'b0, a1}, 32'h5);
    chk("split_sw_w1", {28'b0, w1}, 32'h8);
    chk("split_sw_i1", i1, 32'h00112233);
    xact(1'b0, 3'd2, 32'h13, 32'h0);
    chk("split_lw_rdata", rd, 32'h11223344);
    chk("split_lw_lat", lat, 3);
    xact(1'b0, 3'd1, 32'h3FFF, 32'h0);
    chk("wrap_lh_rdata", rd, 32'h000000AA);
    chk("wrap_lh_lat", lat, 3);
    chk("wrap_lh_a0", {20'b0, a0}, 32'hFFF);
    chk("wrap_lh_a1", {20'b0, a1}, 32'h000);
`else
    xact(1'b1, 3'd2, 32'h13, 32'h11223344);
    chk("nosplit_sw_err", {31'b0, er}, 32'h1);
    chk("nosplit_sw_lat", lat, 1);
    chk("nosplit_sw_we_l", {28'b0, w0}, 32'hF);
    xact(1'b0, 3'd2, 32'h13, 32'h0);
    chk("nosplit_lw_err", {31'b0, er}, 32'h1);
    chk("nosplit_lw_rdata", rd, 32'h0);
    xact(1'b0, 3'd2, 32'h10, 32'h0);
    chk("nosplit_word4_kept", rd, 32'hDEADBEEF);
    xact(1'b0, 3'd2, 32'h14, 32'h0);
    chk("nosplit_word5_kept", rd, 32'h80FF7F01);
    xact(1'b0, 3'd1, 32'h3FFF, 32'h0);
    chk("nosplit_wrap_err", {31'b0, er}, 32'h1);
    chk("nosplit_wrap_lat", lat, 1);
`endif

    // Reset while a store sits in ACC0: the write must be withdrawn at once.
    @(negedge clock);
    for (int n = 0; n < 8 && !lsu_req_ready; n++) @(negedge clock);
    lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_funct3 = 3'd2;
    lsu_req_addr = 32'h30; lsu_req_wdata = 32'h99;
    @(posedge clock);
    #1 lsu_req_valid = 1'b0;
    chk("acc0_we_l_active", {28'b0, dataMem_WE_L}, 32'h0);
    chk("acc0_busy_ready", {31'b0, lsu_req_ready}, 32'h0);
    chk("acc0_addr", {20'b0, dataMem_addr}, 32'hC);
    #2 reset_L = 1'b0;
    #1;
    chk("rst_acc0_we_l", {28'b0, dataMem_WE_L}, 32'hF);
    chk("rst_acc0_in", dataMem_in, 32'h0);
    chk("rst_acc0_addr", {20'b0, dataMem_addr}, 32'h0);
    chk("rst_acc0_ready", {31'b0, lsu_req_ready}, 32'h1);
    saw_resp = lsu_resp_valid;
    repeat (3) begin
      @(negedge clock);
      saw_resp = saw_resp | lsu_resp_valid;
    end
    chk("rst_acc0_no_resp", {31'b0, saw_resp}, 32'h0);
    @(posedge clock);
    #1 reset_L = 1'b1;
    xact(1'b0, 3'd2, 32'h30, 32'h0);
    chk("post_rst_lw_rdata", rd, 32'h0);
    chk("post_rst_lw_lat", lat, 2);
    chk("post_rst_lw_err", {31'b0, er}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
